// File: rtl/alu_pkg.sv
// Shared types for the ALU result checker: opcodes, FSM states, default width.
// No ports; imported by the interface, the reference model and the top.
package alu_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SHL,
    OP_SHR,
    OP_NOT
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/alu_result_checker_if.sv
// Vector handshake bundle: in_valid/in_ready plus opcode, operands and result.
// master drives the vector and reads in_ready; slave (the checker) drives in_ready.
interface alu_result_checker_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_result;

  modport master (
    output in_valid, in_op, in_a, in_b, in_result,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_result,
    output in_ready
  );

endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: in_op, in_a, in_b -> expected, all modulo 2^WIDTH.
// Carry and borrow are dropped; shifts are logical by one bit.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] expected
);

  always_comb begin
    expected = '0;
    unique case (op_e'(in_op))
      OP_ADD: expected = in_a + in_b;
      OP_SUB: expected = in_a - in_b;
      OP_AND: expected = in_a & in_b;
      OP_OR:  expected = in_a | in_b;
      OP_XOR: expected = in_a ^ in_b;
      OP_SHL: expected = in_a << 1;
      OP_SHR: expected = in_a >> 1;
      OP_NOT: expected = ~in_a;
      default: expected = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Checks a run of ALU vectors against alu_ref_model and tallies pass/fail.
// Ports: clk, rst, start, num_vec, bus (slave), busy, done, pass_cnt,
// fail_cnt, error; ff_* first-fail capture when ALU_CHK_FIRSTFAIL_EN is defined.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  alu_result_checker_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             error
`ifdef ALU_CHK_FIRSTFAIL_EN
  ,
  output logic [2:0]       ff_op,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_result,
  output logic [WIDTH-1:0] ff_expected
`endif
);

  state_e           state;
  logic [CNT_W-1:0] nv;
  logic [CNT_W-1:0] acc;
  logic [CNT_W:0]   tally;
  logic             accept;

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_res;
  logic [WIDTH-1:0] s1_exp;

  logic             s2_valid;
  logic             s2_ok;
`ifdef ALU_CHK_FIRSTFAIL_EN
  logic [2:0]       s2_op;
  logic [WIDTH-1:0] s2_a;
  logic [WIDTH-1:0] s2_b;
  logic [WIDTH-1:0] s2_res;
  logic [WIDTH-1:0] s2_exp;
`endif

  assign bus.in_ready = (state == RUN) && (acc < nv);
  assign accept       = bus.in_valid && bus.in_ready;
  assign busy         = (state == RUN);
  assign done         = (state == DONE);
  // Run ends once every requested vector has been tallied.
  assign tally        = {1'b0, pass_cnt} + {1'b0, fail_cnt};

  alu_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .in_op   (s1_op),
    .in_a    (s1_a),
    .in_b    (s1_b),
    .expected(s1_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      nv       <= '0;
      acc      <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      error    <= 1'b0;
`ifdef ALU_CHK_FIRSTFAIL_EN
      ff_op       <= '0;
      ff_a        <= '0;
      ff_b        <= '0;
      ff_result   <= '0;
      ff_expected <= '0;
`endif
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op  <= bus.in_op;
        s1_a   <= bus.in_a;
        s1_b   <= bus.in_b;
        s1_res <= bus.in_result;
        acc    <= acc + 1'b1;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ok  <= (s1_exp == s1_res);
`ifdef ALU_CHK_FIRSTFAIL_EN
        s2_op  <= s1_op;
        s2_a   <= s1_a;
        s2_b   <= s1_b;
        s2_res <= s1_res;
        s2_exp <= s1_exp;
`endif
      end

      if (s2_valid) begin
        if (s2_ok) begin
          pass_cnt <= pass_cnt + 1'b1;
        end else begin
          fail_cnt <= fail_cnt + 1'b1;
          error    <= 1'b1;
`ifdef ALU_CHK_FIRSTFAIL_EN
          // error still low means this is the first mismatch of the run
          if (!error) begin
            ff_op       <= s2_op;
            ff_a        <= s2_a;
            ff_b        <= s2_b;
            ff_result   <= s2_res;
            ff_expected <= s2_exp;
          end
`endif
        end
      end

      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            nv       <= num_vec;
            acc      <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            error    <= 1'b0;
`ifdef ALU_CHK_FIRSTFAIL_EN
            ff_op       <= '0;
            ff_a        <= '0;
            ff_b        <= '0;
            ff_result   <= '0;
            ff_expected <= '0;
`endif
            state <= (num_vec != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (tally == {1'b0, nv}) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, as the ALU operand and result width in bits.
REQ-002 The block SHALL take parameter CNT_W, default 8, as the width of num_vec and both counters.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a check run.
REQ-007 num_vec  input  CNT_W  vectors in the run, sampled on the accepted start.
REQ-008 in_valid / in_ready  input / output  1 each  vector handshake; a beat transfers when both are high on a rising edge.
REQ-009 in_op  input  3  ALU opcode.
REQ-010 in_a, in_b  input  WIDTH each  ALU operands.
REQ-011 in_result  input  WIDTH  ALU output under test.
REQ-012 busy, done  output  1 each  run in progress; run complete.
REQ-013 pass_cnt, fail_cnt  output  CNT_W each  compare tallies.
REQ-014 error  output  1  sticky flag, high after any mismatch.

Function
REQ-015 The expected result SHALL be computed modulo 2^WIDTH, with carry and borrow discarded: op0 a+b, op1 a-b, op2 a&b, op3 a|b, op4 a^b, op5 a<<1, op6 a>>1 (logical), op7 ~a.
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 IDLE->RUN SHALL occur on start when num_vec!=0; IDLE->DONE SHALL occur on start when num_vec==0.
REQ-018 RUN->DONE SHALL occur in the cycle after the final compare updates the counters.
REQ-019 DONE->RUN or DONE->DONE SHALL occur on start, following the same num_vec rule as IDLE; in both cases the counters and error SHALL clear.
REQ-020 start SHALL be ignored while in RUN.
REQ-021 in_ready SHALL be high only in RUN while accepted-beat count < num_vec.
REQ-022 Beats presented while in_ready is low SHALL be ignored.
REQ-023 The pipeline SHALL be two stages: stage 1 registers the accepted beat; stage 2 registers the comparison.
REQ-024 pass_cnt or fail_cnt SHALL increment exactly 2 cycles after the accepting edge.
REQ-025 Back-to-back beats SHALL be accepted every cycle with no bubbles.
REQ-026 error SHALL set together with the first fail_cnt increment and remain set until reset or the next accepted start.
REQ-027 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-028 Counters SHALL never wrap, because pass_cnt+fail_cnt <= num_vec <= 2^CNT_W-1.

Reset
REQ-029 On rst the FSM SHALL go to IDLE; in_ready, busy, done, error and both counters SHALL be 0; pipeline valid bits SHALL clear.
REQ-030 rst asserted mid-run SHALL discard all in-flight beats, with no counter update afterwards.

Configuration
REQ-031 With ALU_CHK_FIRSTFAIL_EN defined, the block SHALL add the outputs ff_op(3), ff_a, ff_b, ff_result and ff_expected(WIDTH each).
REQ-032 With the macro defined, these outputs SHALL capture the first mismatching vector of the run, hold it until reset or the next accepted start, and read 0 before any failure.
REQ-033 Without ALU_CHK_FIRSTFAIL_EN, these ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 A shared package alu_pkg SHALL hold the opcode enum (OP_ADD..OP_NOT, 3 bits), the state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-035 The expected-value computation SHALL be a combinational sub-module alu_ref_model (in_op, in_a, in_b -> expected), instantiated once in stage 1.

Verification
REQ-036 Scenario 1: start with num_vec=6, then beats (0,2,3,5),(1,7,4,3),(2,2,3,2),(3,1,2,3),(4,7,7,0),(5,5,2,10) back-to-back -> pass_cnt=6, fail_cnt=0, error=0, done high 3 cycles after the last accept.
REQ-037 Scenario 2: num_vec=2, beats (0,15,1,0) and (1,0,1,15) -> both pass, confirming wrap-around.
REQ-038 Scenario 3: num_vec=3, second beat (0,2,3,6) -> fail_cnt=1 and error=1; with the macro, ff_result=6 and ff_expected=5 and they do not change on a later failure.
REQ-039 Scenario 4: start with num_vec=0 -> done next cycle, in_ready never high, counters 0.
REQ-040 Scenario 5: num_vec=2 with in_valid held high for 5 cycles -> exactly 2 beats accepted and in_ready low afterwards; start pulsed during RUN has no effect.
REQ-041 Scenario 6: rst asserted 1 cycle after an accept -> all outputs 0, state IDLE, no later counter change.
